// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and writeback stage
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_stall,
    input  logic        in_valid,
    input  logic [15:0] in_instruction,
    input  logic [15:0] in_alu_result,
    input  logic [15:0] in_read_data,
    input  logic [15:0] in_link_pc,
    output logic        rf_we,
    output logic [1:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        fwd_valid,
    output logic [1:0]  fwd_addr,
    output logic [15:0] fwd_data,
    output logic [15:0] output_port,
    output logic        is_halted,
    output logic [15:0] num_inst
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // Link register used by JAL and JRL
    localparam logic [1:0] LINK_REG = 2'd2;

    state_t      state;
    logic [3:0]  opcode;
    logic [5:0]  func;
    logic        dec_we;
    logic [1:0]  dec_waddr;
    logic [15:0] dec_wdata;
    logic        dec_wwd;
    logic        dec_hlt;
    logic        cap;
    logic        unused_bits;

    assign opcode      = in_instruction[15:12];
    assign func        = in_instruction[5:0];
    // rs field is consumed upstream; writeback never needs it
    assign unused_bits = ^in_instruction[11:10];

    // Decode the instruction sitting in MEM into a register-file write request
    always_comb begin
        dec_we    = 1'b0;
        dec_waddr = 2'd0;
        dec_wdata = 16'd0;
        dec_wwd   = 1'b0;
        dec_hlt   = 1'b0;
        unique case (opcode)
            OP_R: begin
                if (func <= 6'd7) begin
                    dec_we    = 1'b1;
                    dec_waddr = in_instruction[7:6];
                    dec_wdata = in_alu_result;
                end else if (func == FN_JRL) begin
                    dec_we    = 1'b1;
                    dec_waddr = LINK_REG;
                    dec_wdata = in_link_pc;
                end else if (func == FN_WWD) begin
                    dec_wwd   = 1'b1;
                end else if (func == FN_HLT) begin
                    dec_hlt   = 1'b1;
                end
            end
            OP_ADI, OP_ORI, OP_LHI: begin
                dec_we    = 1'b1;
                dec_waddr = in_instruction[9:8];
                dec_wdata = in_alu_result;
            end
            OP_LWD: begin
                dec_we    = 1'b1;
                dec_waddr = in_instruction[9:8];
                dec_wdata = in_read_data;
            end
            OP_JAL: begin
                dec_we    = 1'b1;
                dec_waddr = LINK_REG;
                dec_wdata = in_link_pc;
            end
            default: begin
                dec_we    = 1'b0;
            end
        endcase
    end

    // A real instruction retires only when MEM is not stalling and we are not halted
    assign cap = reset_n & ~mem_stall & in_valid & (state == ST_RUN);

    // Run/halt state machine together with the WB register and retirement counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            rf_we       <= 1'b0;
            rf_waddr    <= 2'd0;
            rf_wdata    <= 16'd0;
            output_port <= 16'd0;
            is_halted   <= 1'b0;
            num_inst    <= 16'd0;
        end else begin
            // Write enable is a one-cycle pulse; address/data hold between writes
            rf_we <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cap) begin
                        rf_we    <= dec_we;
                        num_inst <= num_inst + 16'd1;
                        if (dec_we) begin
                            rf_waddr <= dec_waddr;
                            rf_wdata <= dec_wdata;
                        end
                        if (dec_wwd) begin
                            output_port <= in_alu_result;
                        end
                        if (dec_hlt) begin
                            state     <= ST_HALTED;
                            is_halted <= 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state     <= ST_HALTED;
                    is_halted <= 1'b1;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Forwarding bus mirrors the WB register so EX sees the value being written
    assign fwd_valid = rf_we;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk;
    logic        reset_n;
    logic        mem_stall;
    logic        in_valid;
    logic [15:0] in_instruction;
    logic [15:0] in_alu_result;
    logic [15:0] in_read_data;
    logic [15:0] in_link_pc;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        fwd_valid;
    logic [1:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic [15:0] output_port;
    logic        is_halted;
    logic [15:0] num_inst;

    mem_wb_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_stall      (mem_stall),
        .in_valid       (in_valid),
        .in_instruction (in_instruction),
        .in_alu_result  (in_alu_result),
        .in_read_data   (in_read_data),
        .in_link_pc     (in_link_pc),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .fwd_valid      (fwd_valid),
        .fwd_addr       (fwd_addr),
        .fwd_data       (fwd_data),
        .output_port    (output_port),
        .is_halted      (is_halted),
        .num_inst       (num_inst)
    );

    localparam logic [15:0] I_ADI_R1 = 16'h4100;
    localparam logic [15:0] I_LWD_R3 = 16'h7300;
    localparam logic [15:0] I_JAL    = 16'hA000;
    localparam logic [15:0] I_SWD    = 16'h8000;
    localparam logic [15:0] I_ADD_R3 = 16'hF0C0;
    localparam logic [15:0] I_JRL    = 16'hF01A;
    localparam logic [15:0] I_WWD    = 16'hF01C;
    localparam logic [15:0] I_HLT    = 16'hF01D;

    typedef struct {
        int          cyc;
        string       name;
        logic        we;
        logic [1:0]  addr;
        logic [15:0] data;
        logic [15:0] outp;
        logic        halt;
        logic [15:0] num;
    } exp_t;

    exp_t expq[$];
    int   cyc;
    int   tests;
    int   fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after each rising edge, compare every expectation due on this edge
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            while (expq.size() > 0 && expq[0].cyc <= cyc) begin
                exp_t e;
                e = expq.pop_front();
                tests = tests + 1;
                if (e.cyc != cyc ||
                    rf_we !== e.we || rf_waddr !== e.addr || rf_wdata !== e.data ||
                    fwd_valid !== e.we || fwd_addr !== e.addr || fwd_data !== e.data ||
                    output_port !== e.outp || is_halted !== e.halt || num_inst !== e.num) begin
                    fails = fails + 1;
                    $display("FAIL %s cyc=%0d/%0d got we=%b addr=%0d data=%h fwd=%b/%0d/%h out=%h halt=%b num=%h required we=%b addr=%0d data=%h out=%h halt=%b num=%h",
                             e.name, cyc, e.cyc, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
                             output_port, is_halted, num_inst, e.we, e.addr, e.data, e.outp, e.halt, e.num);
                end
            end
        end
    end

    // Drive one cycle of inputs at the falling edge; optionally queue the result due after the next rising edge
    task automatic step(input string name, input logic rst_n, input logic stall, input logic valid,
                        input logic [15:0] instr, input logic [15:0] alu, input logic [15:0] rd,
                        input logic [15:0] link, input logic chk,
                        input logic ewe, input logic [1:0] eaddr, input logic [15:0] edata,
                        input logic [15:0] eout, input logic ehalt, input logic [15:0] enum_);
        exp_t e;
        @(negedge clk);
        reset_n        = rst_n;
        mem_stall      = stall;
        in_valid       = valid;
        in_instruction = instr;
        in_alu_result  = alu;
        in_read_data   = rd;
        in_link_pc     = link;
        if (chk) begin
            e.cyc  = cyc + 1;
            e.name = name;
            e.we   = ewe;
            e.addr = eaddr;
            e.data = edata;
            e.outp = eout;
            e.halt = ehalt;
            e.num  = enum_;
            expq.push_back(e);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        reset_n        = 1'b0;
        mem_stall      = 1'b0;
        in_valid       = 1'b0;
        in_instruction = 16'h0;
        in_alu_result  = 16'h0;
        in_read_data   = 16'h0;
        in_link_pc     = 16'h0;

        // Reset wins over a valid ADI in MEM
        step("reset0", 0, 0, 1, I_ADI_R1, 16'h9999, 16'h0, 16'h0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'd0);
        step("reset1", 0, 0, 1, I_ADI_R1, 16'h9999, 16'h0, 16'h0, 1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'd0);
        // ADI r1 then a bubble
        step("adi_r1", 1, 0, 1, I_ADI_R1, 16'h1234, 16'h0, 16'h0, 1, 1, 2'd1, 16'h1234, 16'h0000, 0, 16'd1);
        step("bubble", 1, 0, 0, I_ADI_R1, 16'h7777, 16'h0, 16'h0, 1, 0, 2'd1, 16'h1234, 16'h0000, 0, 16'd1);
        // LWD r3 held by a 4-cycle MEM stall, valid asserted throughout
        for (int i = 0; i < 4; i++)
            step("lwd_stall", 1, 1, 1, I_LWD_R3, 16'h0003, 16'hDEAD, 16'h0, 1, 0, 2'd1, 16'h1234, 16'h0000, 0, 16'd1);
        step("lwd_r3", 1, 0, 1, I_LWD_R3, 16'h0003, 16'hBEEF, 16'h0, 1, 1, 2'd3, 16'hBEEF, 16'h0000, 0, 16'd2);
        step("lwd_post", 1, 0, 0, I_LWD_R3, 16'h0003, 16'hBEEF, 16'h0, 1, 0, 2'd3, 16'hBEEF, 16'h0000, 0, 16'd2);
        // JAL, SWD, bubble
        step("jal", 1, 0, 1, I_JAL, 16'h5A5A, 16'h0, 16'h0042, 1, 1, 2'd2, 16'h0042, 16'h0000, 0, 16'd3);
        step("swd", 1, 0, 1, I_SWD, 16'h0010, 16'h0, 16'h0043, 1, 0, 2'd2, 16'h0042, 16'h0000, 0, 16'd4);
        step("bubble2", 1, 0, 0, I_SWD, 16'h0010, 16'h0, 16'h0044, 1, 0, 2'd2, 16'h0042, 16'h0000, 0, 16'd4);
        // R-type ALU to rd=3 and JRL to the link register
        step("add_r3", 1, 0, 1, I_ADD_R3, 16'h0F0F, 16'h0, 16'h0050, 1, 1, 2'd3, 16'h0F0F, 16'h0000, 0, 16'd5);
        step("jrl", 1, 0, 1, I_JRL, 16'h1111, 16'h0, 16'h0077, 1, 1, 2'd2, 16'h0077, 16'h0000, 0, 16'd6);
        // WWD, HLT, then ADIs that must be ignored
        step("wwd", 1, 0, 1, I_WWD, 16'h00AA, 16'h0, 16'h0078, 1, 0, 2'd2, 16'h0077, 16'h00AA, 0, 16'd7);
        step("hlt", 1, 0, 1, I_HLT, 16'h0000, 16'h0, 16'h0079, 1, 0, 2'd2, 16'h0077, 16'h00AA, 1, 16'd8);
        step("halt_adi", 1, 0, 1, I_ADI_R1, 16'h5555, 16'h0, 16'h007A, 1, 0, 2'd2, 16'h0077, 16'h00AA, 1, 16'd8);
        step("halt_adi2", 1, 0, 1, I_ADI_R1, 16'h6666, 16'h0, 16'h007B, 1, 0, 2'd2, 16'h0077, 16'h00AA, 1, 16'd8);
        // Reset leaves HALTED and clears everything
        step("reset2", 0, 0, 0, I_SWD, 16'h0000, 16'h0, 16'h0000, 1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'd0);
        // Counter wrap: 65535 SWD retirements, then one more
        for (int i = 0; i < 65534; i++)
            step("pre", 1, 0, 1, I_SWD, 16'h0000, 16'h0, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'd0);
        step("num_ffff", 1, 0, 1, I_SWD, 16'h0000, 16'h0, 16'h0000, 1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'hFFFF);
        step("num_wrap", 1, 0, 1, I_SWD, 16'h0000, 16'h0, 16'h0000, 1, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);
        step("idle", 1, 0, 0, I_SWD, 16'h0000, 16'h0, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 16'h0000);

        // Give the monitor a bounded window to drain the scoreboard
        for (int i = 0; i < 4 && expq.size() > 0; i++)
            @(negedge clk);
        if (expq.size() > 0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL drain got %0d pending expectations required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
